mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
Multi-cycle shift-and-add multiplier controller that executes the processor's MUL4bits/SMUL-class instructions. It is started by the decode stage and stalls instruction fetch while busy. On completion it issues a single register-file write strobe. It sits beside the ALU, between decode and the register-file write port.

Parameters:
WIDTH, 16, operand width in bits; product is 2*WIDTH.
ADDR_W, 8, register destination address width (matches instruction destination field).

Ports:
Clock  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-low reset.
iStart  input  1  one-cycle request from decode; sampled only in IDLE.
iSigned  input  1  operands are two's complement (used only with SIGNED_MUL_EN).
iDestAddr  input  ADDR_W  destination register for the product.
iA  input  WIDTH  multiplicand (src1).
iB  input  WIDTH  multiplier (src0).
oBusy  output  1  high in any state other than IDLE.
oStall  output  1  combinational: (IDLE and iStart) or oBusy; holds PC/ROM address.
oWriteEnable  output  1  one-cycle register-file write strobe.
oWriteAddr  output  ADDR_W  destination register, valid with oWriteEnable.
oResult  output  2*WIDTH  product, valid with oWriteEnable; held until next write.
oDone  output  1  one-cycle completion pulse, coincident with oWriteEnable.

Behaviour:
- Reset (Reset=0, async): state=IDLE, count=0, accumulator=0, oResult=0, oWriteAddr=0, oWriteEnable=0, oDone=0, oBusy=0.
- States: IDLE, RUN, WRITE (FIX only with SIGNED_MUL_EN).
- IDLE: on iStart=1 at a rising edge, latch iA into multiplicand, iB into multiplier, iDestAddr into destination, clear accumulator and count, go to RUN.
- RUN: each cycle, if multiplier[0]=1 then accumulator += multiplicand (2*WIDTH bits, zero-extended). Then multiplicand <<= 1, multiplier >>= 1, count++. After WIDTH RUN cycles (count = WIDTH-1 on the final cycle), go to WRITE.
- WRITE: oResult=accumulator, oWriteEnable=1, oDone=1, oWriteAddr=latched destination, for exactly one cycle. Then go to IDLE.
- Latency: iStart sampled at edge N; oDone high during cycle N+WIDTH+1 (17 cycles for WIDTH=16). Fixed latency, with no early-out on zero operands.
- iStart while busy: ignored, with no queuing. Decode must not issue, and oStall already prevents it.
- iStart in the same cycle as WRITE: ignored. A new start is accepted only in the IDLE cycle after WRITE, so back-to-back operations are WIDTH+2 cycles apart.
- Reset mid-operation: immediate abort to IDLE. No write strobe is issued and oResult returns to 0.
- Arithmetic: unsigned product is exact, so no overflow is possible in 2*WIDTH bits. The accumulator never wraps.

Optional Feature:
Macro SIGNED_MUL_EN.
- Defined, with iSigned=1 at start: latch |iA| and |iB| (magnitudes as unsigned WIDTH-bit values, so -2^(WIDTH-1) maps to 2^(WIDTH-1)) and record sign = iA[MSB]^iB[MSB].
- After RUN the block enters FIX for one cycle: accumulator = sign ? -accumulator : accumulator (2*WIDTH two's complement). Signed latency is therefore WIDTH+2.
- Defined, with iSigned=0: identical to the unsigned path, with no FIX state.
- Undefined: iSigned is ignored, there is no FIX state and no magnitude logic, and all operations are unsigned.

Decomposition:
- Shared definitions file (the existing definitions include): state encodings (IDLE, RUN, WRITE, FIX) and the MUL4bits/SMUL opcode constants used by decode to drive iStart/iSigned.
- One natural sub-module, mul_datapath: accumulator, shift registers and adder/negator. It is controlled by the mul_sequencer FSM and counter.

Test Plan:
- iA=0x0002, iB=0x0004, iDestAddr=5 -> oResult=0x00000008, oWriteAddr=5, oDone exactly 17 cycles after start; oStall high from the start cycle through WRITE.
- iA=0xFFFF, iB=0xFFFF unsigned -> oResult=0xFFFE0001; iA=0, iB=0x1234 -> oResult=0, same 17-cycle latency.
- Reset driven low at RUN cycle 8 -> outputs zero immediately, no oWriteEnable pulse; a subsequent 3*3 yields 9 normally.
- iStart pulsed at cycles 3 and 10 of a busy operation -> ignored, exactly one oDone. Start asserted in the IDLE cycle after WRITE -> accepted, second result correct.
- SIGNED_MUL_EN, iSigned=1: iA=0xFFFD (-3), iB=0x0005 -> 0xFFFFFFF1 at 18 cycles; iA=0x8000, iB=0x8000 -> 0x40000000; iA=0xFFFF, iB=0xFFFF -> 0x00000001.
- Without SIGNED_MUL_EN, iSigned=1, iA=0xFFFD, iB=0x0005 -> unsigned 0x0004FFF1 at 17 cycles.

Source files
------------

// File: rtl/mul_sequencer_pkg.sv
// ============================================================================
// Module      : mul_sequencer_pkg
// Description : State encodings and decode opcodes for the shift-add
//               multiplier sequencer. ST_FIX is reachable only when
//               SIGNED_MUL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_sequencer_pkg;

   localparam int ST_W = 2;

   localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [ST_W-1:0] ST_RUN   = 2'd1;
   localparam logic [ST_W-1:0] ST_WRITE = 2'd2;
   localparam logic [ST_W-1:0] ST_FIX   = 2'd3;

   // Decode raises iStart for either opcode and iSigned only for SMUL
   localparam logic [5:0] OPC_MUL4BITS = 6'h2C;
   localparam logic [5:0] OPC_SMUL     = 6'h2D;

   function automatic logic is_mul_op(input logic [5:0] opc);
      return (opc == OPC_MUL4BITS) || (opc == OPC_SMUL);
   endfunction

   function automatic logic is_signed_mul_op(input logic [5:0] opc);
      return (opc == OPC_SMUL);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mul_datapath.sv
// ============================================================================
// Module      : mul_datapath
// Description : Accumulator, multiplicand/multiplier shift registers and the
//               result negator. Sign handling exists only with SIGNED_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_datapath #(
   parameter int WIDTH = 16
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 i_load,
   input  logic                 i_step,
`ifdef SIGNED_MUL_EN
   input  logic                 i_signed,
   input  logic                 i_fix,
`endif
   input  logic [WIDTH-1:0]     i_a,
   input  logic [WIDTH-1:0]     i_b,
   output logic [2*WIDTH-1:0]   o_acc
);

   logic [2*WIDTH-1:0] r_mcand;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_mplier;
   logic [WIDTH-1:0]   w_a_ld;
   logic [WIDTH-1:0]   w_b_ld;

`ifdef SIGNED_MUL_EN
   logic r_sign;
   logic w_neg_a;
   logic w_neg_b;

   assign w_neg_a = i_signed & i_a[WIDTH-1];
   assign w_neg_b = i_signed & i_b[WIDTH-1];
   // Unsigned WIDTH-bit magnitude: the most negative value maps onto itself
   assign w_a_ld  = w_neg_a ? -i_a : i_a;
   assign w_b_ld  = w_neg_b ? -i_b : i_b;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_sign <= 1'b0;
      end else if (i_load) begin
         r_sign <= w_neg_a ^ w_neg_b;
      end
   end
`else
   assign w_a_ld = i_a;
   assign w_b_ld = i_b;
`endif

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
      end else if (i_load) begin
         r_mcand  <= {{WIDTH{1'b0}}, w_a_ld};
         r_mplier <= w_b_ld;
         r_acc    <= '0;
      end else if (i_step) begin
         if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
         end
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
      end
`ifdef SIGNED_MUL_EN
      else if (i_fix && r_sign) begin
         r_acc <= -r_acc;
      end
`endif
   end

   assign o_acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/mul_sequencer.sv
// ============================================================================
// Module      : mul_sequencer
// Description : Fixed-latency shift-and-add multiplier controller issuing one
//               register-file write per operation. Optional macro
//               SIGNED_MUL_EN adds two's-complement operands via a FIX state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_sequencer #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 8
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 iStart,
   input  logic                 iSigned,
   input  logic [ADDR_W-1:0]    iDestAddr,
   input  logic [WIDTH-1:0]     iA,
   input  logic [WIDTH-1:0]     iB,
   output logic                 oBusy,
   output logic                 oStall,
   output logic                 oWriteEnable,
   output logic [ADDR_W-1:0]    oWriteAddr,
   output logic [2*WIDTH-1:0]   oResult,
   output logic                 oDone
);

   import mul_sequencer_pkg::*;

   localparam int               CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

   logic [ST_W-1:0]    r_state;
   logic [CNT_W-1:0]   r_count;
   logic [ADDR_W-1:0]  r_dest;
   logic [2*WIDTH-1:0] r_result;
   logic [ADDR_W-1:0]  r_waddr;
   logic               r_we;
   logic               r_done;

   logic               w_idle;
   logic               w_load;
   logic               w_step;
   logic [2*WIDTH-1:0] w_acc;
   logic [ST_W-1:0]    w_after_run;

   assign w_idle = (r_state == ST_IDLE);
   assign w_load = w_idle & iStart;
   assign w_step = (r_state == ST_RUN);

`ifdef SIGNED_MUL_EN
   logic r_signed_op;
   logic w_fix;

   assign w_fix       = (r_state == ST_FIX);
   assign w_after_run = r_signed_op ? ST_FIX : ST_WRITE;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_signed_op <= 1'b0;
      end else if (w_load) begin
         r_signed_op <= iSigned;
      end
   end
`else
   logic w_unused_signed;

   assign w_unused_signed = iSigned;
   assign w_after_run     = ST_WRITE;
`endif

   mul_datapath #(
      .WIDTH    (WIDTH)
   ) u_datapath (
      .Clock    (Clock),
      .Reset    (Reset),
      .i_load   (w_load),
      .i_step   (w_step),
`ifdef SIGNED_MUL_EN
      .i_signed (iSigned),
      .i_fix    (w_fix),
`endif
      .i_a      (iA),
      .i_b      (iB),
      .o_acc    (w_acc)
   );

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state  <= ST_IDLE;
         r_count  <= '0;
         r_dest   <= '0;
         r_result <= '0;
         r_waddr  <= '0;
         r_we     <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_we   <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (iStart) begin
                  r_state <= ST_RUN;
                  r_count <= '0;
                  r_dest  <= iDestAddr;
               end
            end
            ST_RUN: begin
               r_count <= r_count + CNT_W'(1);
               if (r_count == C_LAST) begin
                  r_state <= w_after_run;
               end
            end
`ifdef SIGNED_MUL_EN
            ST_FIX: begin
               r_state <= ST_WRITE;
            end
`endif
            ST_WRITE: begin
               r_result <= w_acc;
               r_waddr  <= r_dest;
               r_we     <= 1'b1;
               r_done   <= 1'b1;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign oBusy        = ~w_idle;
   assign oStall       = w_load | ~w_idle;
   assign oWriteEnable = r_we;
   assign oWriteAddr   = r_waddr;
   assign oResult      = r_result;
   assign oDone        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mul_sequencer.sv
// ============================================================================
// Module      : tb_mul_sequencer
// Description : Directed self-checking bench for mul_sequencer; expected
//               values for signed vectors depend on SIGNED_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_sequencer;

   localparam int WIDTH  = 16;
   localparam int ADDR_W = 8;

   logic                Clock = 1'b0;
   logic                Reset;
   logic                iStart;
   logic                iSigned;
   logic [ADDR_W-1:0]   iDestAddr;
   logic [WIDTH-1:0]    iA;
   logic [WIDTH-1:0]    iB;
   logic                oBusy;
   logic                oStall;
   logic                oWriteEnable;
   logic [ADDR_W-1:0]   oWriteAddr;
   logic [2*WIDTH-1:0]  oResult;
   logic                oDone;

   int vectors     = 0;
   int miscompares = 0;

   mul_sequencer #(
      .WIDTH        (WIDTH),
      .ADDR_W       (ADDR_W)
   ) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .iStart       (iStart),
      .iSigned      (iSigned),
      .iDestAddr    (iDestAddr),
      .iA           (iA),
      .iB           (iB),
      .oBusy        (oBusy),
      .oStall       (oStall),
      .oWriteEnable (oWriteEnable),
      .oWriteAddr   (oWriteAddr),
      .oResult      (oResult),
      .oDone        (oDone)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Starts at a negedge, returns at the negedge of the oDone cycle
   task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sgn, input logic [ADDR_W-1:0] dest,
                         input logic [2*WIDTH-1:0] exp_res, input int exp_lat, input bit pulse_mid);
      int lat;
      bit stall_ok;
      iA = a; iB = b; iSigned = sgn; iDestAddr = dest; iStart = 1'b1;
      #1 check({tag, " stall_at_start"}, oStall, 1);
      @(negedge Clock);
      iStart   = 1'b0;
      lat      = 0;
      stall_ok = 1'b1;
      while (!oDone && lat < 40) begin
         if (!oStall || !oBusy) stall_ok = 1'b0;
         iStart = pulse_mid && (lat == 2 || lat == 9);
         if (iStart) begin
            iA = '1; iB = '1; iDestAddr = 8'hEE;
         end
         @(negedge Clock);
         lat++;
      end
      iStart = 1'b0;
      check({tag, " latency"},  lat,          exp_lat);
      check({tag, " result"},   oResult,      exp_res);
      check({tag, " waddr"},    oWriteAddr,   dest);
      check({tag, " we"},       oWriteEnable, 1);
      check({tag, " stall"},    stall_ok,     1);
      check({tag, " idle"},     oBusy,        0);
   endtask

   initial begin : main
      int n;
      Reset = 1'b0; iStart = 1'b0; iSigned = 1'b0; iDestAddr = '0; iA = '0; iB = '0;
      @(negedge Clock);
      @(negedge Clock);
      check("rst busy",  oBusy,        0);
      check("rst stall", oStall,       0);
      check("rst we",    oWriteEnable, 0);
      check("rst done",  oDone,        0);
      check("rst res",   oResult,      0);
      check("rst waddr", oWriteAddr,   0);
      Reset = 1'b1;
      @(negedge Clock);

      run_op("2x4", 16'h0002, 16'h0004, 1'b0, 8'd5, 32'h0000_0008, 17, 1'b0);
      @(negedge Clock);
      check("2x4 done_one_cycle", oDone,        0);
      check("2x4 we_one_cycle",   oWriteEnable, 0);
      check("2x4 held",           oResult,      32'h0000_0008);

      run_op("ffff_sq", 16'hFFFF, 16'hFFFF, 1'b0, 8'd7, 32'hFFFE_0001, 17, 1'b0);
      @(negedge Clock);
      run_op("zero", 16'h0000, 16'h1234, 1'b0, 8'd9, 32'h0000_0000, 17, 1'b0);
      @(negedge Clock);
`ifdef SIGNED_MUL_EN
      run_op("m3x5", 16'hFFFD, 16'h0005, 1'b1, 8'd3, 32'hFFFF_FFF1, 18, 1'b0);
      @(negedge Clock);
      run_op("min_sq", 16'h8000, 16'h8000, 1'b1, 8'd4, 32'h4000_0000, 18, 1'b0);
      @(negedge Clock);
      run_op("m1_sq", 16'hFFFF, 16'hFFFF, 1'b1, 8'd6, 32'h0000_0001, 18, 1'b0);
      @(negedge Clock);
`else
      run_op("m3x5", 16'hFFFD, 16'h0005, 1'b1, 8'd3, 32'h0004_FFF1, 17, 1'b0);
      @(negedge Clock);
`endif

      // Second start lands in the IDLE cycle right after WRITE
      run_op("b2b_a", 16'h0010, 16'h0011, 1'b0, 8'h21, 32'h0000_0110, 17, 1'b0);
      run_op("b2b_b", 16'h0006, 16'h0007, 1'b0, 8'h22, 32'h0000_002A, 17, 1'b0);
      @(negedge Clock);

      run_op("busy_start", 16'h0101, 16'h0003, 1'b0, 8'h30, 32'h0000_0303, 17, 1'b1);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge Clock);
         if (oDone) n++;
      end
      check("busy_start extra_done", n, 0);

      iA = 16'h1234; iB = 16'h0010; iSigned = 1'b0; iDestAddr = 8'h44; iStart = 1'b1;
      @(negedge Clock);
      iStart = 1'b0;
      repeat (9) @(negedge Clock);
      check("pre_abort busy", oBusy, 1);
      Reset = 1'b0;
      #1;
      check("abort busy",  oBusy,      0);
      check("abort res",   oResult,    0);
      check("abort waddr", oWriteAddr, 0);
      check("abort stall", oStall,     0);
      @(negedge Clock);
      Reset = 1'b1;
      n = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge Clock);
         if (oWriteEnable) n++;
      end
      check("abort no_write", n, 0);
      run_op("3x3", 16'h0003, 16'h0003, 1'b0, 8'd1, 32'h0000_0009, 17, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
